// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: opcodes, instruction
// classes, FSM state encodings and datapath mux select codes.
package mips_ctrl_pkg;

  // Primary opcode field, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Instruction class codes
  localparam logic [2:0] CLS_NONE = 3'b000;
  localparam logic [2:0] CLS_R    = 3'b001;
  localparam logic [2:0] CLS_LW   = 3'b010;
  localparam logic [2:0] CLS_SW   = 3'b011;
  localparam logic [2:0] CLS_BEQ  = 3'b100;
  localparam logic [2:0] CLS_J    = 3'b101;
  localparam logic [2:0] CLS_ILL  = 3'b111;

  // Sequencer states; encodings are visible on the state port
  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StRWb     = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWb   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StHalt    = 4'd15
  } state_t;

  // PC source select
  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_BR   = 2'd1;
  localparam logic [1:0] PC_SRC_JMP  = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

endpackage

// File: rtl/mips_class_dec.sv
// Opcode to instruction-class decoder; purely combinational, shared with the main decoder.
module mips_class_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] cls
);

  // Map the primary opcode onto its class; unknown opcodes are illegal
  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_RTYPE: cls = CLS_R;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_BEQ:   cls = CLS_BEQ;
      OP_J:     cls = CLS_J;
      default:  cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath. Fetches through a req/ack memory
// port, decodes the opcode into a class and steps the datapath through per-class phases.
// Optional feature: define MIPS_CTRL_PERF_EN to add the 32-bit retired-instruction counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit RST_PC_SEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [2:0]  cls,
  output logic [3:0]  state,
  output logic        busy,
  output logic        illegal
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] retired
`endif
);

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  logic [2:0] cls_q;
  logic       illegal_q;
  logic [2:0] dec_cls;
  state_t     boundary;

  // Only the opcode field is consumed here; the rest belongs to the datapath
  logic unused_instr;
  assign unused_instr = ^instr[25:0];

  mips_class_dec u_class_dec (
    .opcode (opcode_q),
    .cls    (dec_cls)
  );

  // Instruction boundary: continue fetching while run is high, otherwise park in IDLE
  assign boundary = run ? StFetch : StIdle;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = run ? StFetch : StIdle;
      StFetch:   state_d = mem_ack ? StDecode : StFetch;
      StDecode: begin
        case (dec_cls)
          CLS_R:          state_d = StExecR;
          CLS_LW, CLS_SW: state_d = StMemAddr;
          CLS_BEQ:        state_d = StBranch;
          CLS_J:          state_d = StJump;
          default:        state_d = StHalt;
        endcase
      end
      StExecR:   state_d = StRWb;
      StRWb:     state_d = boundary;
      // cls_q was loaded at the DECODE edge, so it already names lw vs sw here
      StMemAddr: state_d = (cls_q == CLS_LW) ? StMemRd : StMemWr;
      StMemRd:   state_d = mem_ack ? StMemWb : StMemRd;
      StMemWb:   state_d = boundary;
      StMemWr:   state_d = mem_ack ? boundary : StMemWr;
      StBranch:  state_d = boundary;
      StJump:    state_d = boundary;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
  end

  // State, opcode, class and sticky flags; reset is synchronous and beats a pending ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      opcode_q  <= 6'd0;
      cls_q     <= CLS_NONE;
      illegal_q <= 1'b0;
`ifdef MIPS_CTRL_PERF_EN
      retired   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && mem_ack) opcode_q <= instr[31:26];
      if (state_q == StDecode) begin
        cls_q <= dec_cls;
        if (dec_cls == CLS_ILL) illegal_q <= 1'b1;
      end
`ifdef MIPS_CTRL_PERF_EN
      // Count completions on the transition out of each instruction's final phase
      if ((state_q inside {StRWb, StMemWb, StBranch, StJump}) ||
          (state_q == StMemWr && mem_ack)) begin
        retired <= retired + 32'd1;
      end
`endif
    end
  end

  // Datapath strobes: Moore per state, plus the Mealy fetch-acknowledge terms
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_PC4;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      StIdle:    iord = RST_PC_SEL;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          pc_src    = PC_SRC_PC4;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
        end
      end
      // Precompute the branch target while the class is resolved
      StDecode:  alu_src_b = SRCB_IMM_SH;
      StExecR: begin
        alu_op    = ALUOP_FUNCT;
        alu_src_b = SRCB_REG;
      end
      StRWb: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      StMemAddr: alu_src_b = SRCB_IMM;
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      StBranch: begin
        alu_op    = ALUOP_SUB;
        alu_src_b = SRCB_REG;
        pc_src    = PC_SRC_BR;
        pc_we     = alu_zero;
      end
      StJump: begin
        pc_we  = 1'b1;
        pc_src = PC_SRC_JMP;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign cls     = cls_q;
  assign illegal = illegal_q;
  assign busy    = (state_q != StIdle) && (state_q != StHalt);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and randomized instruction streams compared
// cycle by cycle against a per-class phase model built from the instruction's class.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, mem_ack, alu_zero;
  logic [31:0] instr;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [2:0]  cls;
  logic [3:0]  state;
  logic        busy, illegal;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] retired;
`endif

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .instr      (instr),
    .mem_ack    (mem_ack),
    .alu_zero   (alu_zero),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .cls        (cls),
    .state      (state),
    .busy       (busy),
    .illegal    (illegal)
`ifdef MIPS_CTRL_PERF_EN
    ,
    .retired    (retired)
`endif
  );

  always #5 clk = ~clk;

  // One expected cycle: stimulus to drive plus outputs to expect
  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] sig;
    logic [2:0]  cls;
    logic        ack;
    logic        zero;
    logic        runv;
    logic        rstv;
    logic [31:0] ret;
  } cyc_t;

  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  int          cur_st = 0;
  logic [31:0] ret_cnt  = 32'd0;
  logic [2:0]  prev_cls = 3'd0;

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s (expected state %0d) observed=%0h expected=%0h", tag, cur_st, obs, exp);
    end
  endtask

  // Strobe vector: req we iord ir_we pc_we pc_src[2] srcb[2] alu_op[2] reg_we reg_dst m2r
  function automatic logic [13:0] sg(input logic req, input logic we, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] ps,
                                     input logic [1:0] sb, input logic [1:0] ao,
                                     input logic rw, input logic rd, input logic m2r);
    return {req, we, io, irw, pcw, ps, sb, ao, rw, rd, m2r};
  endfunction

  function automatic logic [2:0] class_of(input logic [5:0] op);
    case (op)
      6'd0:    return 3'd1;
      6'd35:   return 3'd2;
      6'd43:   return 3'd3;
      6'd4:    return 3'd4;
      6'd2:    return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // Ack and alu_zero are scrambled wherever the controller should ignore them
  function automatic cyc_t mk(input logic [3:0] st, input logic [13:0] sig,
                              input logic [2:0] c);
    cyc_t e;
    e      = '0;
    e.st   = st;
    e.sig  = sig;
    e.cls  = c;
    e.ack  = (st == 4'd1 || st == 4'd6 || st == 4'd8) ? 1'b0 : 1'($urandom_range(0, 1));
    e.zero = 1'($urandom_range(0, 1));
    e.runv = 1'b1;
    e.rstv = 1'b1;
    e.ret  = ret_cnt;
    return e;
  endfunction

  task automatic drive(input cyc_t e, input logic [31:0] ins);
    logic [31:0] r;
    logic [13:0] obs;
    r        = $urandom;
    rst_n    = e.rstv;
    run      = e.runv;
    mem_ack  = e.ack;
    alu_zero = e.zero;
    instr    = (e.st == 4'd1 && e.ack) ? ins : r;
    cur_st   = int'(e.st);
    @(negedge clk);
    obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b, alu_op,
           reg_we, reg_dst, mem_to_reg};
    chk("state", 32'(state), 32'(e.st));
    chk("strobes", 32'(obs), 32'(e.sig));
    chk("cls", 32'(cls), 32'(e.cls));
    chk("busy", 32'(busy), 32'(e.st != 4'd0 && e.st != 4'd15));
    chk("illegal", 32'(illegal), 32'(e.st == 4'd15));
`ifdef MIPS_CTRL_PERF_EN
    chk("retired", retired, e.ret);
`endif
    @(posedge clk);
    #1;
  endtask

  // Build the phase list for one instruction from its class, then play it
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                          input logic stop, input logic abort);
    cyc_t       q[$];
    cyc_t       e;
    logic [2:0] c;
    int         nfetch;
    c = class_of(ins[31:26]);
    for (int i = 0; i < fw; i++)
      q.push_back(mk(4'd1, sg(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0), prev_cls));
    e = mk(4'd1, sg(1, 0, 0, 1, 1, 2'd0, 2'd1, 2'd0, 0, 0, 0), prev_cls);
    e.ack = 1'b1;
    q.push_back(e);
    nfetch = q.size();
    q.push_back(mk(4'd2, sg(0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd0, 0, 0, 0), prev_cls));
    case (c)
      3'd1: begin
        q.push_back(mk(4'd3, sg(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0, 0, 0), c));
        q.push_back(mk(4'd4, sg(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0), c));
      end
      3'd2, 3'd3: begin
        q.push_back(mk(4'd5, sg(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 0, 0, 0), c));
        if (abort) begin
          // Reset lands on the first MEM_RD cycle together with an ack
          e = mk(4'd6, sg(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0), c);
          e.ack  = 1'b1;
          e.rstv = 1'b0;
          q.push_back(e);
          e = mk(4'd0, 14'd0, 3'd0);
          e.ack  = 1'b1;
          e.runv = 1'b0;
          e.ret  = 32'd0;
          q.push_back(e);
          e = mk(4'd0, 14'd0, 3'd0);
          e.ret = 32'd0;
          q.push_back(e);
        end else if (c == 3'd2) begin
          for (int i = 0; i <= mw; i++) begin
            e = mk(4'd6, sg(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0), c);
            e.ack = (i == mw);
            q.push_back(e);
          end
          q.push_back(mk(4'd7, sg(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 1), c));
        end else begin
          for (int i = 0; i <= mw; i++) begin
            e = mk(4'd8, sg(1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0), c);
            e.ack = (i == mw);
            q.push_back(e);
          end
        end
      end
      3'd4: begin
        e = mk(4'd9, sg(0, 0, 0, 0, z, 2'd1, 2'd0, 2'd1, 0, 0, 0), c);
        e.zero = z;
        q.push_back(e);
      end
      3'd5: q.push_back(mk(4'd10, sg(0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0, 0, 0), c));
      default: begin
        for (int i = 0; i < 10; i++) begin
          e = mk(4'd15, 14'd0, c);
          e.runv = 1'($urandom_range(0, 1));
          q.push_back(e);
        end
      end
    endcase
    if (stop)
      for (int i = nfetch; i < q.size(); i++) q[i].runv = 1'b0;
    if (abort) begin
      ret_cnt  = 32'd0;
      prev_cls = 3'd0;
    end else begin
      if (c != 3'd7) ret_cnt = ret_cnt + 32'd1;
      prev_cls = c;
    end
    if (stop) begin
      e = mk(4'd0, 14'd0, c);
      e.runv = 1'b0;
      q.push_back(e);
      q.push_back(mk(4'd0, 14'd0, c));
    end
    foreach (q[i]) drive(q[i], ins);
  endtask

  initial begin
    cyc_t        e;
    logic [5:0]  ops [5];
    logic [31:0] r;
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd2;
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b1; alu_zero = 1'b0; instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, then start running
    e = mk(4'd0, 14'd0, 3'd0);
    e.runv = 1'b0;
    drive(e, 32'd0);
    drive(mk(4'd0, 14'd0, 3'd0), 32'd0);

    // Directed: add, lw with 2 waits, sw, beq taken / not taken
    do_instr(32'h02328020, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h8E300020, 0, 2, 1'b0, 1'b0, 1'b0);
    do_instr(32'hAE300020, 1, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h121100C8, 0, 0, 1'b1, 1'b0, 1'b0);
    do_instr(32'h121100C8, 2, 0, 1'b0, 1'b0, 1'b0);

    // Random legal stream with waits; run drops mid-instruction twice
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      do_instr({ops[$urandom_range(0, 4)], r[25:0]}, $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), (i == 7 || i == 23), 1'b0);
    end

    // Reset in the middle of a load, with a late ack afterwards
    do_instr(32'h8E300020, 0, 0, 1'b0, 1'b0, 1'b1);

    // Jump, then an illegal opcode that parks the sequencer in HALT
    do_instr(32'h080003E8, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'hFC000000, 1, 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
